serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//   Bit-serial WIDTH-bit adder that steps one full-adder bit cell over two operands, LSB first.
//   A registered carry is fed back into the cell on every cycle, so one bit is resolved per clock.
//   Sits between operand registers and any consumer that accepts a multi-cycle result.
//   Trades latency for area against a WIDTH-bit parallel ripple adder.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range WIDTH >= 2
// PORTS
//   clk     in   1      single clock, rising edge
//   rst_n   in   1      asynchronous, active-low reset
//   start   in   1      request; sampled only in IDLE or DONE
//   a       in   WIDTH  operand A; captured on the accepting edge
//   b       in   WIDTH  operand B; captured on the accepting edge
//   cin     in   1      carry-in; captured on the accepting edge
//   busy    out  1      high while in RUN
//   done    out  1      one-cycle pulse; result valid
//   sum     out  WIDTH  result; held stable from done until the next accept
//   cout    out  1      carry out of the MSB; held with sum
//   ovf     out  1      signed overflow (present only with OVERFLOW_FLAG_EN)
// BEHAVIOUR
//   - Reset (rst_n=0, takes effect immediately):
//     - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
//     - Operand shift registers, carry register and bit counter all clear to 0.
//   - Bit cell: s = a_i ^ b_i ^ c; co = (a_i&b_i) | (a_i&c) | (b_i&c).
//   - Internal registers:
//     - sa, sb: WIDTH-bit shift registers holding the operands.
//     - c: 1-bit carry register.
//     - cnt: $clog2(WIDTH)-bit bit counter.
//     - acc: WIDTH-bit result shift register.
//   - State IDLE: on an edge with start=1:
//     - load sa=a, sb=b, c=cin, cnt=0, acc=0;
//     - go to RUN.
//   - State RUN: each edge:
//     - acc <= {s, acc[WIDTH-1:1]} (result shifts in from the MSB end);
//     - sa, sb shift right by one;
//     - c <= co; cnt <= cnt+1.
//     - When cnt==WIDTH-1 on that edge: go to DONE.
//   - State DONE (exactly one cycle):
//     - done=1, busy=0; sum=acc; cout=c.
//     - Next edge: start=1 reloads as in IDLE and goes to RUN (back-to-back, zero bubble);
//       otherwise go to IDLE.
//   - Latency: accepting edge E0, then RUN edges E1..EW; done is high in the cycle after EW.
//     Issue interval is WIDTH+1 cycles.
//   - sum/cout (and ovf) are registered outputs, updated only on the edge entering DONE;
//     they hold their value through IDLE and RUN.
//   - start during RUN is ignored; it is not queued. a, b and cin may change freely after E0.
//   - cnt wraps only by reload; it never counts past WIDTH-1.
//   - Reset mid-RUN aborts the operation: no done pulse, outputs forced to their reset values.
// CONFIGURATION
//   OVERFLOW_FLAG_EN defined:
//     - Port ovf exists.
//     - On the MSB step (cnt==WIDTH-1) register ovf <= c ^ co
//       (carry into MSB XOR carry out of MSB).
//     - ovf is valid and held alongside sum.
//   OVERFLOW_FLAG_EN undefined:
//     - Port ovf and its register are absent.
//     - All other behaviour is identical.
// TESTING (WIDTH=8)
//   1. Reset, then start with a=0x35, b=0x4A, cin=0 -> busy for 8 cycles; done pulse 9 cycles
//      after the accept; sum=0x7F, cout=0.
//   2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. With the macro defined: ovf=0.
//   3. a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then start held high in the DONE cycle with
//      a=0x01, b=0x02 -> busy rises with no gap; second done gives sum=0x03.
//   4. Pulse start again at RUN cycle 3 with different operands -> ignored; result matches the
//      first operands only; exactly one done pulse.
//   5. Drop rst_n at RUN cycle 4 -> busy=0, sum=0, cout=0 immediately; no done pulse.
//      The next start completes correctly.
//   6. With OVERFLOW_FLAG_EN: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1;
//      then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder step per clock, LSB first
//   Ports: clk, rst_n (async active-low), start, a, b, cin in;
//          busy (high in RUN), done (one-cycle result pulse), sum, cout,
//          ovf (signed overflow, only when OVERFLOW_FLAG_EN is defined) out.
//   Optional feature macro: OVERFLOW_FLAG_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] sa, sb, acc;
  logic [CW-1:0] cnt;
  logic c, s, co, last, accept;
  assign s      = sa[0] ^ sb[0] ^ c;
  assign co     = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
  assign last   = cnt == CW'(WIDTH - 1);
  assign accept = (state != RUN) && start;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  // IDLE and DONE react identically to start, which gives zero-bubble back-to-back issue
  always_comb begin
    state_nxt = state;
    state_nxt = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      acc  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf  <= 1'b0;
`endif
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      c   <= cin;
      cnt <= '0;
      acc <= '0;
    end else if (state == RUN) begin
      acc <= {s, acc[WIDTH-1:1]};
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      c   <= co;
      // cnt parks at WIDTH-1 so it never overruns for non-power-of-two widths
      cnt <= last ? cnt : cnt + CW'(1);
      if (last) begin
        sum  <= {s, acc[WIDTH-1:1]};
        cout <= co;
`ifdef OVERFLOW_FLAG_EN
        ovf  <= c ^ co;
`endif
      end
    end
  end
endmodule
